// File: rtl/dmem_arbiter.sv
// Shares one single-ported registered data RAM between the core data port and an aux master.
// Core has default priority; a wait counter forces aux in, and a bounded burst limits the stall.
module dmem_arbiter #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CLEAR,

    input  logic                 c_mem_read,
    input  logic                 c_mem_write,
    input  logic [ADDR_SIZE-1:0] c_daddr,
    input  logic [DATA_SIZE-1:0] c_ddata_w,
    output logic [DATA_SIZE-1:0] c_ddata_r,
    output logic                 c_stall,

    input  logic                 a_mem_read,
    input  logic                 a_mem_write,
    input  logic [ADDR_SIZE-1:0] a_daddr,
    input  logic [DATA_SIZE-1:0] a_ddata_w,
    output logic                 a_grant,
    output logic [DATA_SIZE-1:0] a_ddata_r,
    output logic                 a_rvalid,

    output logic [ADDR_SIZE-1:0] daddr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [DATA_SIZE-1:0] ddata_w,
    input  logic [DATA_SIZE-1:0] ddata_r
);

    localparam logic [3:0] WaitLast  = 4'(MAX_WAIT - 1);
    localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        StCore = 1'b0,
        StAux  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pending_q, rd_owner_q;

    logic clr;
    logic c_req, a_req;
    logic grant_c, grant_a;

    assign clr   = !RESET_N || CLEAR;
    assign c_req = c_mem_read | c_mem_write;
    assign a_req = a_mem_read | a_mem_write;

    // No grant is ever issued while reset or clear is active.
    always_comb begin
        grant_c = 1'b0;
        grant_a = 1'b0;
        if (!clr) begin
            case (state_q)
                StCore: begin
                    if (c_req) begin
                        grant_c = 1'b1;
                    end else if (a_req) begin
                        grant_a = 1'b1;
                    end
                end
                StAux: begin
                    if (a_req) begin
                        grant_a = 1'b1;
                    end else if (c_req) begin
                        grant_c = 1'b1;
                    end
                end
                default: begin
                    grant_c = 1'b0;
                    grant_a = 1'b0;
                end
            endcase
        end
    end

    // RAM port steering; a write wins over a simultaneous read from the same master.
    always_comb begin
        daddr     = c_daddr;
        ddata_w   = c_ddata_w;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (grant_a) begin
            daddr     = a_daddr;
            ddata_w   = a_ddata_w;
            mem_write = a_mem_write;
            mem_read  = a_mem_read & ~a_mem_write;
        end else if (grant_c) begin
            mem_write = c_mem_write;
            mem_read  = c_mem_read & ~c_mem_write;
        end
    end

    assign c_stall   = c_req & ~grant_c;
    assign a_grant   = grant_a;
    assign c_ddata_r = ddata_r;
    assign a_ddata_r = ddata_r;
    assign a_rvalid  = !clr && rd_pending_q && rd_owner_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;

        if (!a_req || grant_a) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        case (state_q)
            StCore: begin
                if (a_req && !grant_a && wait_cnt_q == WaitLast) begin
                    state_d     = StAux;
                    burst_cnt_d = 4'd0;
                end
            end
            StAux: begin
                if (!a_req || burst_cnt_q == BurstLast) begin
                    state_d     = StCore;
                    burst_cnt_d = 4'd0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = StCore;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q      <= StCore;
            wait_cnt_q   <= 4'd0;
            burst_cnt_q  <= 4'd0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            // Tracker is overwritten every cycle so back-to-back reads each get their slot.
            rd_pending_q <= mem_read;
            rd_owner_q   <= grant_a;
        end
    end

endmodule
